// File: rtl/id_pkg.sv
// Shared definitions for the decode-stage scoreboard: register index type,
// ARM register field positions and the PC index.
package id_pkg;

    localparam int DEF_NREGS = 16;
    localparam int REG_IDX_W = 4;
    localparam int PC_IDX    = DEF_NREGS - 1;

    localparam int RN_LSB = 16;
    localparam int RD_LSB = 12;
    localparam int RS_LSB = 8;
    localparam int RM_LSB = 0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic reg_idx_t reg_field(input logic [31:0] instr, input int lsb);
        return instr[lsb +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/id_scoreboard_stage_sb_counter.sv
// Saturating up/down pending-write counter for one architectural register,
// with a sticky flag raised by a release while nothing is pending.
module sb_counter #(
    parameter int MAX_PEND = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inc,
    input  logic                          dec,
    output logic [$clog2(MAX_PEND+1)-1:0] count,
    output logic                          underflow
);

    localparam int CNT_W = $clog2(MAX_PEND + 1);

    // Simultaneous issue and release cancel out; an empty release only flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count != CNT_W'(MAX_PEND))
                        count <= count + CNT_W'(1);
                end
                2'b01: begin
                    if (count == '0)
                        underflow <= 1'b1;
                    else
                        count <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/id_scoreboard_stage.sv
// Decode slot with per-register pending-write scoreboard between fetch and execute.
// Optional macro ID_SB_BYPASS_EN lets a same-cycle writeback release clear a hazard.
module id_scoreboard_stage
    import id_pkg::*;
#(
    parameter int INSTR_W  = 32,
    parameter int NREGS    = DEF_NREGS,
    parameter int MAX_PEND = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid_i,
    input  logic [INSTR_W-1:0]       instr_i,
    input  logic [INSTR_W-1:0]       pc8_i,
    output logic                     instr_ready_o,
    output logic [INSTR_W-1:0]       instr_d_o,
    output logic [INSTR_W-1:0]       pc8_d_o,
    input  logic                     dec_use_a_i,
    input  logic                     dec_use_b_i,
    input  logic                     dec_use_s_i,
    input  logic                     dec_wr_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    input  logic                     flush_i,
    input  logic                     wb_valid_i,
    input  logic [$clog2(NREGS)-1:0] wb_rd_i,
    output logic                     sb_err_o
);

    localparam int WB_W  = $clog2(NREGS);
    localparam int CNT_W = $clog2(MAX_PEND + 1);
    localparam int NCNT  = NREGS - 1;

    logic               d_valid;
    logic [INSTR_W-1:0] instr_d;
    logic [INSTR_W-1:0] pc8_d;
    logic               hazard;
    logic               fire;
    reg_idx_t           rn_idx, rm_idx, rs_idx, rd_idx;
    logic [CNT_W-1:0]   pend [NCNT];
    logic [NCNT-1:0]    cnt_inc, rel_hit, cnt_err;

    assign rn_idx = reg_field(instr_d[31:0], RN_LSB);
    assign rm_idx = reg_field(instr_d[31:0], RM_LSB);
    assign rs_idx = reg_field(instr_d[31:0], RS_LSB);
    assign rd_idx = reg_field(instr_d[31:0], RD_LSB);

    assign out_valid_o   = d_valid & ~hazard & ~flush_i;
    assign fire          = out_valid_o & out_ready_i;
    assign instr_ready_o = ~flush_i & (~d_valid | fire);
    assign instr_d_o     = instr_d;
    assign pc8_d_o       = pc8_d;
    assign sb_err_o      = |cnt_err;

    // The PC has no counter, so it can never cause a hazard.
    for (genvar r = 0; r < NCNT; r++) begin : g_cnt
        assign rel_hit[r] = wb_valid_i && (wb_rd_i == WB_W'(r));
        assign cnt_inc[r] = fire && dec_wr_i && (rd_idx == reg_idx_t'(r));

        sb_counter #(.MAX_PEND(MAX_PEND)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (cnt_inc[r]),
            .dec       (rel_hit[r]),
            .count     (pend[r]),
            .underflow (cnt_err[r])
        );
    end

    // Source registers must have nothing pending; the destination must have room.
    always_comb begin
        logic [CNT_W-1:0] eff;
        hazard = 1'b0;
        eff    = '0;
        for (int r = 0; r < NCNT; r++) begin
            eff = pend[r];
`ifdef ID_SB_BYPASS_EN
            if (rel_hit[r] && (pend[r] != '0))
                eff = pend[r] - CNT_W'(1);
`endif
            if (((dec_use_a_i && (rn_idx == reg_idx_t'(r))) ||
                 (dec_use_b_i && (rm_idx == reg_idx_t'(r))) ||
                 (dec_use_s_i && (rs_idx == reg_idx_t'(r)))) && (eff != '0))
                hazard = 1'b1;
            if (dec_wr_i && (rd_idx == reg_idx_t'(r)) && (eff == CNT_W'(MAX_PEND)))
                hazard = 1'b1;
        end
    end

    // Flush wins over a load so the incoming instruction is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid <= 1'b0;
            instr_d <= '0;
            pc8_d   <= '0;
        end else if (flush_i) begin
            d_valid <= 1'b0;
        end else if (instr_valid_i && instr_ready_o) begin
            d_valid <= 1'b1;
            instr_d <= instr_i;
            pc8_d   <= pc8_i;
        end else if (fire) begin
            d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_scoreboard_stage.sv
// Directed self-checking bench for id_scoreboard_stage; a toy decoder maps
// instruction bits 31..28 to use_a/use_b/use_s/wr.
module tb_id_scoreboard_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic [31:0] pc8_i;
    logic        instr_ready_o;
    logic [31:0] instr_d_o;
    logic [31:0] pc8_d_o;
    logic        dec_use_a_i, dec_use_b_i, dec_use_s_i, dec_wr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        flush_i;
    logic        wb_valid_i;
    logic [3:0]  wb_rd_i;
    logic        sb_err_o;

    int assert_count = 0;
    int fail_count   = 0;

`ifdef ID_SB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    assign dec_use_a_i = instr_d_o[31];
    assign dec_use_b_i = instr_d_o[30];
    assign dec_use_s_i = instr_d_o[29];
    assign dec_wr_i    = instr_d_o[28];

    id_scoreboard_stage dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .pc8_i         (pc8_i),
        .instr_ready_o (instr_ready_o),
        .instr_d_o     (instr_d_o),
        .pc8_d_o       (pc8_d_o),
        .dec_use_a_i   (dec_use_a_i),
        .dec_use_b_i   (dec_use_b_i),
        .dec_use_s_i   (dec_use_s_i),
        .dec_wr_i      (dec_wr_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .flush_i       (flush_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .sb_err_o      (sb_err_o)
    );

    function automatic logic [31:0] mk(input logic wr, input logic ua, input logic ub,
                                       input logic us, input logic [3:0] rd,
                                       input logic [3:0] rn, input logic [3:0] rm,
                                       input logic [7:0] tag);
        return {ua, ub, us, wr, tag, rn, rd, 4'h0, 4'h0, rm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic ordy,
                                 input logic fl, input logic wbv, input logic [3:0] wbr);
        instr_valid_i = iv;
        instr_i       = ins;
        pc8_i         = ins + 32'd8;
        out_ready_i   = ordy;
        flush_i       = fl;
        wb_valid_i    = wbv;
        wb_rd_i       = wbr;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] adds [4];
    logic [31:0] add_r1, sub_r2, x6, y, rd6, w5a, w5b, rd5, rd7;
    logic [31:0] w4 [4];

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        #10;
        checkOutput("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("rst_ready", {31'b0, instr_ready_o}, 32'd1);
        checkOutput("rst_instr_d", instr_d_o, 32'd0);
        checkOutput("rst_pc8_d", pc8_d_o, 32'd0);
        checkOutput("rst_sb_err", {31'b0, sb_err_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Four independent ADDs streamed back to back
        for (int k = 0; k < 4; k++)
            adds[k] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'(k + 1), 4'h0, 4'h0, 8'(8'h10 + k));
        applyStimulus(1'b1, adds[0], 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t1_first_ready", {31'b0, instr_ready_o}, 32'd1);
        checkOutput("t1_first_no_valid", {31'b0, out_valid_o}, 32'd0);
        tick();
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b1, adds[k], 1'b1, 1'b0, 1'b0, 4'h0);
            checkOutput("t1_stream_valid", {31'b0, out_valid_o}, 32'd1);
            checkOutput("t1_stream_ready", {31'b0, instr_ready_o}, 32'd1);
            checkOutput("t1_stream_instr", instr_d_o, adds[k-1]);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t1_last_valid", {31'b0, out_valid_o}, 32'd1);
        checkOutput("t1_last_pc8", pc8_d_o, adds[3] + 32'd8);
        tick();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'(k));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t1_no_err", {31'b0, sb_err_o}, 32'd0);
        checkOutput("t1_empty", {31'b0, out_valid_o}, 32'd0);

        // RAW dependency: SUB r2,r1,r3 after ADD r1
        add_r1 = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 4'd0, 8'h20);
        sub_r2 = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 4'd3, 8'h21);
        applyStimulus(1'b1, add_r1, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b1, sub_r2, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t2_add_fire", {31'b0, out_valid_o}, 32'd1);
        tick();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
            checkOutput("t2_raw_stall", {31'b0, out_valid_o}, 32'd0);
            checkOutput("t2_raw_not_ready", {31'b0, instr_ready_o}, 32'd0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd1);
        checkOutput("t2_release_cycle", {31'b0, out_valid_o}, {31'b0, BYP});
        tick();
`ifndef ID_SB_BYPASS_EN
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t2_issue_after_release", {31'b0, out_valid_o}, 32'd1);
        checkOutput("t2_issue_instr", instr_d_o, sub_r2);
        tick();
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd2);
        checkOutput("t2_slot_empty", {31'b0, out_valid_o}, 32'd0);
        tick();

        // Write-count saturation on r4
        for (int k = 0; k < 4; k++)
            w4[k] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 8'(8'h40 + k));
        applyStimulus(1'b1, w4[0], 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b1, w4[k], 1'b1, 1'b0, 1'b0, 4'h0);
            checkOutput("t3_write_fire", {31'b0, out_valid_o}, 32'd1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
            checkOutput("t3_sat_stall", {31'b0, out_valid_o}, 32'd0);
            checkOutput("t3_sat_instr", instr_d_o, w4[3]);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd4);
        checkOutput("t3_release_cycle", {31'b0, out_valid_o}, {31'b0, BYP});
        tick();
`ifndef ID_SB_BYPASS_EN
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t3_issue_after_release", {31'b0, out_valid_o}, 32'd1);
        tick();
`endif
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd4);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t3_no_err", {31'b0, sb_err_o}, 32'd0);

        // Flush kills the held write and drops the incoming instruction
        x6  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 4'd0, 8'h60);
        y   = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 4'd0, 8'h61);
        rd6 = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd6, 4'd0, 8'h62);
        applyStimulus(1'b1, x6, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b1, y, 1'b1, 1'b1, 1'b0, 4'h0);
        checkOutput("t4_flush_no_fire", {31'b0, out_valid_o}, 32'd0);
        checkOutput("t4_flush_not_ready", {31'b0, instr_ready_o}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t4_slot_empty", {31'b0, out_valid_o}, 32'd0);
        checkOutput("t4_ready_again", {31'b0, instr_ready_o}, 32'd1);
        checkOutput("t4_incoming_dropped", instr_d_o, x6);
        applyStimulus(1'b1, rd6, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t4_counter_untouched", {31'b0, out_valid_o}, 32'd1);
        tick();

        // Same-cycle issue of a write to r5 and release of r5
        w5a = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 8'h50);
        w5b = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 8'h51);
        rd5 = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd5, 8'h52);
        applyStimulus(1'b1, w5a, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b1, w5b, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t6_first_fire", {31'b0, out_valid_o}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd5);
        checkOutput("t6_fire_with_release", {31'b0, out_valid_o}, 32'd1);
        tick();
        applyStimulus(1'b1, rd5, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t6_pend_still_one", {31'b0, out_valid_o}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd5);
        checkOutput("t6_release_cycle", {31'b0, out_valid_o}, {31'b0, BYP});
        tick();
`ifndef ID_SB_BYPASS_EN
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t6_issue_after_release", {31'b0, out_valid_o}, 32'd1);
        tick();
`endif
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t6_no_err", {31'b0, sb_err_o}, 32'd0);

        // Release with nothing pending on r7 sets the sticky error
        rd7 = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 8'h70);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd7);
        checkOutput("t5_err_not_yet", {31'b0, sb_err_o}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t5_err_set", {31'b0, sb_err_o}, 32'd1);
        tick();
        tick();
        checkOutput("t5_err_sticky", {31'b0, sb_err_o}, 32'd1);
        applyStimulus(1'b1, rd7, 1'b1, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t5_pend_zero", {31'b0, out_valid_o}, 32'd1);
        tick();

        // Asynchronous reset while an instruction is held
        applyStimulus(1'b1, w5a, 1'b0, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("mid_held", instr_d_o, w5a);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'b0, out_valid_o}, 32'd0);
        checkOutput("mid_rst_instr", instr_d_o, 32'd0);
        checkOutput("mid_rst_pc8", pc8_d_o, 32'd0);
        checkOutput("mid_rst_err", {31'b0, sb_err_o}, 32'd0);
        checkOutput("mid_rst_ready", {31'b0, instr_ready_o}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/id_scoreboard_stage.md
# id_scoreboard_stage

Parametrised decode-stage pipeline slot with a register scoreboard, sitting between fetch and execute in the pipelined ARM core. It holds one fetched instruction with valid/ready handshakes on both sides, and exposes it to the combinational decoder. It tracks in-flight register writes with per-register pending counters. It stalls issue on read-after-write or write-count hazards, supports flush, and takes release pulses from writeback.

## Interface
- INSTR_W, 32, instruction and PC width
- NREGS, 16, architectural register count; index NREGS-1 is the PC
- MAX_PEND, 3, maximum outstanding writes tracked per register (counter saturation limit)
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- instr_valid_i  input  1  fetch presents an instruction
- instr_i  input  INSTR_W  fetched instruction
- pc8_i  input  INSTR_W  PC+8 of the fetched instruction
- instr_ready_o  output  1  decode slot accepts this cycle
- instr_d_o  output  INSTR_W  held instruction, to decoder
- pc8_d_o  output  INSTR_W  held PC+8
- dec_use_a_i / dec_use_b_i / dec_use_s_i  input  1 each  decoder: Rn [19:16], Rm [3:0], Rs [11:8] are read
- dec_wr_i  input  1  decoder: Rd [15:12] is written
- out_valid_o  output  1  instruction issuable to execute
- out_ready_i  input  1  execute accepts
- flush_i  input  1  kill the held instruction
- wb_valid_i  input  1  writeback release pulse
- wb_rd_i  input  $clog2(NREGS)  register being released
- sb_err_o  output  1  sticky: release of a register with zero pending

## Operation
- Slot state: d_valid, instr_d, pc8_d. Load when instr_valid_i & instr_ready_o.
- instr_ready_o = ~flush_i & (~d_valid | fire), where fire = out_valid_o & out_ready_i.
- hazard = any used source with pend[src] != 0, or dec_wr_i & pend[Rd] == MAX_PEND. The PC index is exempt from both checks and is never counted.
- out_valid_o = d_valid & ~hazard & ~flush_i.
- On fire with dec_wr_i: pend[Rd] += 1. On wb_valid_i: pend[wb_rd_i] -= 1.
- Increment and decrement on the same register in the same cycle: net unchanged.
- Decrement at 0: count stays 0 and sb_err_o is set until reset.
- Increment never exceeds MAX_PEND, which the hazard rule guarantees.
- flush_i: d_valid <= 0 next edge, incoming instruction dropped, no fire that cycle.
- Counters are untouched by flush. Squashed downstream instructions with dec_wr must still send their release pulse.
- Reset: d_valid=0, instr_d_o=0, pc8_d_o=0, all pend=0, sb_err_o=0, hence out_valid_o=0 and instr_ready_o=1.

## Timing
- Instruction accepted at edge N: on instr_d_o after edge N; earliest fire in cycle N+1.
- Sustained throughput is 1 instruction/cycle with no hazards. Back-to-back accept-and-fire in the same cycle is permitted.
- Counter changes are visible to the hazard check in the cycle after the edge that applies them, unless bypass is enabled.
- out_valid_o may drop while out_ready_i is low only through flush_i; a hazard cannot appear on a held instruction except through counters, which only rise on fire.
- Reset mid-operation clears everything asynchronously; no release pulses are expected afterwards.

## Configuration
- ID_SB_BYPASS_EN defined: the hazard check uses pend minus a same-cycle matching wb_valid_i release. A dependent instruction then issues in the same cycle its producer releases.
- ID_SB_BYPASS_EN undefined: the check uses registered counts only, which costs one extra stall cycle per RAW dependency.

## Structure
- Package id_pkg holds:
  - the register index type
  - field position constants (RN_LSB=16, RD_LSB=12, RS_LSB=8, RM_LSB=0)
  - PC_IDX = NREGS-1
- Sub-module sb_counter is a single saturating up/down pending counter with underflow flag. It is generated NREGS-1 times (PC excluded).
- The existing decoder stays external and is driven from instr_d_o.

## Test plan
- Reset, then stream 4 independent ADDs with out_ready_i=1 -> one fire per cycle from cycle 1, all pend stay at peak 1 then 0, sb_err_o=0.
- ADD r1 then SUB r2,r1,r3, no release -> second stalls with out_valid_o=0. Pulse wb_rd_i=1 -> issues the next cycle; with ID_SB_BYPASS_EN it issues the same cycle.
- Three writes to r4 issued, a fourth write to r4 held -> stalls at pend=3 until one release, then fires.
- flush_i asserted while d_valid=1 and instr_valid_i=1 -> no fire, instr_ready_o=0, slot empty next cycle, counters unchanged.
- wb_valid_i to r7 with pend[r7]=0 -> sb_err_o=1 and stays set; pend[r7]=0.
- Same-cycle fire writing r5 and release of r5 with pend=1 -> pend[r5] stays 1.
